// File: rtl/mul_final_adder.sv
// Final carry-propagate adder for the 16x16 Booth/Wallace multiplier, split at SPLIT over 2 stages.
// Latency 2 cycles, 1/cycle throughput; a stalled output holds both stages and drops in_ready when full.
module mul_final_adder #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_c,
  input  logic [1:0]       in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int HW = WIDTH - SPLIT;

  typedef struct packed {
    logic [HW-1:0]    s_hi;
    logic [HW-1:0]    cv_hi;
    logic             k;
    logic [SPLIT-1:0] lo;
  } s1_t;

  logic [WIDTH-1:0] cv;
  logic [SPLIT:0]   low_sum;
  logic [HW-1:0]    hi_sum;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_ready;
  logic             in_fire;
  logic             out_fire;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // neg[0] fills the vacated LSB of the shifted carry vector, neg[1] rides the low-half carry-in
  always_comb begin
    cv         = {in_c[WIDTH-2:0], in_neg[0]};
    low_sum    = {1'b0, in_s[SPLIT-1:0]} + {1'b0, cv[SPLIT-1:0]} + {{SPLIT{1'b0}}, in_neg[1]};
    s1_d.s_hi  = in_s[WIDTH-1:SPLIT];
    s1_d.cv_hi = cv[WIDTH-1:SPLIT];
    s1_d.k     = low_sum[SPLIT];
    s1_d.lo    = low_sum[SPLIT-1:0];
  end

  assign hi_sum = s1_q.s_hi + s1_q.cv_hi + {{(HW-1){1'b0}}, s1_q.k};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) out_prod <= {hi_sum, s1_q.lo};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           res_cnt <= '0;
    else if (out_fire) res_cnt <= res_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mul_final_adder.sv
// Directed table, handshake corner sequences and a random soak for mul_final_adder.
module tb_mul_final_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_s = '0;
  logic [31:0] in_c = '0;
  logic [1:0]  in_neg = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic [15:0] res_cnt;

  logic        ready_cmd = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        rnd_rdy = 1'b1;
  assign out_ready = rand_rdy ? rnd_rdy : ready_cmd;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];

  typedef struct {
    logic [31:0] s;
    logic [31:0] c;
    logic [1:0]  neg;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  mul_final_adder #(.WIDTH(32), .SPLIT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_c(in_c), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rand_rdy) begin
    #2;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Scoreboard: every handed-off product must be the oldest outstanding expected value
  always @(negedge clk) if (!rst && out_valid && out_ready) begin
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_output: got %h expected none", out_prod);
    end else begin
      chk("product", out_prod, q.pop_front());
    end
  end

  task automatic send(input logic [31:0] s, input logic [31:0] c, input logic [1:0] neg,
                      input logic [31:0] exp);
    logic acc;
    acc = 1'b0;
    in_s = s; in_c = c; in_neg = neg; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) q.push_back(exp);
    else chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rs, rc, rexp;
    logic [1:0]  rn;

    tbl[0] = '{32'h0000FFFF, 32'h00000000, 2'b01, 32'h00010000};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 2'b10, 32'h00000000};
    tbl[2] = '{32'h00000000, 32'h80000000, 2'b00, 32'h00000000};
    tbl[3] = '{32'h12345678, 32'h11111111, 2'b11, 32'h3456789C};
    tbl[4] = '{32'h00007FFF, 32'h00004000, 2'b11, 32'h00010001};
    tbl[5] = '{32'hAAAAAAAA, 32'h2AAAAAAA, 2'b00, 32'hFFFFFFFE};

    // Reset state
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", out_prod, 32'd0);
    chk("rst_res_cnt", 32'(res_cnt), 32'd0);
    step();

    // Directed table: each result appears two cycles after its accept cycle
    ready_cmd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].s, tbl[i].c, tbl[i].neg, tbl[i].exp);
      chk("lat_s1_only", 32'(out_valid), 32'd0);
      step();
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_out_prod", out_prod, tbl[i].exp);
      drain();
    end
    chk("table_res_cnt", 32'(res_cnt), 32'd6);

    // Back-to-back from a clean reset: one handoff per cycle
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    q.delete();
    step();
    for (int i = 0; i < 4; i++) send(32'h100 * i + 32'd1, 32'd1, 2'b00, 32'h100 * i + 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_res_cnt", 32'(res_cnt), 32'(2 + i));
      step();
    end
    chk("b2b_idle", 32'(out_valid), 32'd0);
    chk("b2b_total", 32'(res_cnt), 32'd4);

    // Backpressure: A and B buffered, C refused while the output stalls
    ready_cmd = 1'b0;
    send(32'h00000001, 32'h00000001, 2'b00, 32'h00000003);
    send(32'h00000100, 32'h00000000, 2'b01, 32'h00000101);
    in_s = 32'hFFFF0000; in_c = 32'h7FFF8000; in_neg = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_prod", out_prod, 32'h00000003);
      step();
    end
    ready_cmd = 1'b1;
    send(32'hFFFF0000, 32'h7FFF8000, 2'b00, 32'hFFFE0000);
    drain();
    chk("bp_res_cnt", 32'(res_cnt), 32'd7);

    // Async reset with both stages occupied
    ready_cmd = 1'b0;
    send(32'd5, 32'd0, 2'b00, 32'd5);
    send(32'd6, 32'd0, 2'b00, 32'd6);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_prod", out_prod, 32'd0);
    chk("arst_res_cnt", 32'(res_cnt), 32'd0);
    q.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_flushed", 32'(out_valid), 32'd0);
    step();
    ready_cmd = 1'b1;
    send(32'd3, 32'd2, 2'b00, 32'd7);
    drain();
    chk("arst_res_cnt_after", 32'(res_cnt), 32'd1);

    // Random soak with random gaps and random downstream stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      repeat ($urandom_range(0, 1)) step();
      rs = $urandom;
      rc = $urandom;
      rn = 2'($urandom_range(0, 3));
      rexp = rs + {rc[30:0], rn[0]} + {31'd0, rn[1]};
      send(rs, rc, rn, rexp);
    end
    rand_rdy = 1'b0;
    drain();
    chk("rand_res_cnt", 32'(res_cnt), 32'(10001 % 65536));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
